// File: rtl/psum_glb_pkg.sv
// Shared types, constants and the saturating-add helper for the psum bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package psum_glb_pkg;

  localparam int DATA_BITWIDTH     = 16;
  localparam int ADDR_BITWIDTH_GLB = 10;

  typedef logic signed [DATA_BITWIDTH-1:0] psum_t;
  typedef logic [ADDR_BITWIDTH_GLB-1:0]    addr_t;

  localparam psum_t PSUM_MAX = psum_t'({1'b0, {(DATA_BITWIDTH-1){1'b1}}});
  localparam psum_t PSUM_MIN = psum_t'({1'b1, {(DATA_BITWIDTH-1){1'b0}}});

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Write request captured at accept and carried into the modify/write stage.
  typedef struct packed {
    addr_t addr;
    psum_t data;
    logic  mode;
  } wr_stage_t;

  typedef struct packed {
    logic  sat;
    psum_t sum;
  } sat_res_t;

  // Signed add that clamps to the representable range and reports the clamp.
  function automatic sat_res_t sat_add(input psum_t a, input psum_t b);
    logic [DATA_BITWIDTH:0] wide;
    sat_res_t               res;
    wide    = {a[DATA_BITWIDTH-1], a} + {b[DATA_BITWIDTH-1], b};
    res.sat = wide[DATA_BITWIDTH] ^ wide[DATA_BITWIDTH-1];
    if (!res.sat)
      res.sum = psum_t'(wide[DATA_BITWIDTH-1:0]);
    else if (wide[DATA_BITWIDTH])
      res.sum = PSUM_MIN;
    else
      res.sum = PSUM_MAX;
    return res;
  endfunction

endpackage

// File: rtl/psum_bank_ram.sv
// Simple dual-port psum storage: one synchronous read port, one write port.
// Latency: read data appears the cycle after rd_en; write lands at the clock edge.
// Backpressure: none; read-during-write to one address returns the old word.
module psum_bank_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; output holds between reads so the S2 stage can consume it.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/glb_psum_accum.sv
// Psum bank: overwrite/accumulate read-modify-write pipeline, read port, clear sweep.
// Latency: write committed at end of the cycle after accept; read data one cycle after accept.
// Backpressure: write_ready low during clear; reads yield to writes. PSUM_SAT_EN selects saturating accumulate.
module glb_psum_accum
  import psum_glb_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en_glb_psum,
  input  logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]     w_data_glb_psum,
  input  logic                         accum_mode,
  output logic                         write_ready,
  input  logic                         read_en,
  input  logic [ADDR_BITWIDTH_GLB-1:0] r_addr,
  output logic                         read_ready,
  output logic [DATA_BITWIDTH-1:0]     r_data,
  output logic                         r_valid,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         sat_flag
);

  clr_state_t clr_state;
  addr_t      clr_addr;
  logic       clr_pend;
  logic       clr_busy_q;
  logic       clr_go;
  logic       out_of_rst;

  wr_stage_t  s2;
  logic       s2_vld;
  psum_t      s2_old;
  psum_t      s2_sum;
  psum_t      s2_new;
  logic       wb_vld;
  addr_t      wb_addr;
  psum_t      wb_data;

  logic       wr_acc;
  logic       rd_acc;
  logic       rd_fwd_q;
  psum_t      rd_fwd_dat_q;

  logic       ram_ren;
  addr_t      ram_raddr;
  psum_t      ram_q;
  logic       ram_we;
  addr_t      ram_waddr;
  psum_t      ram_wdata;

  assign write_ready = out_of_rst && !clr_busy_q;
  assign read_ready  = write_ready && !write_en_glb_psum;
  assign wr_acc      = write_en_glb_psum && write_ready;
  assign rd_acc      = read_en && read_ready;
  assign clear_busy  = clr_busy_q;

  // A sweep may only start with the write pipe empty so the RAM write port is free.
  assign clr_go = (clr_state == IDLE) && (clear_start || clr_pend) && !s2_vld && !wr_acc;

  // The single RAM read port serves the S1 read of an accepted write, else an external read.
  assign ram_ren   = wr_acc || rd_acc;
  assign ram_raddr = wr_acc ? w_addr_glb_psum : r_addr;
  assign ram_we    = s2_vld || clr_busy_q;
  assign ram_waddr = clr_busy_q ? clr_addr : s2.addr;
  assign ram_wdata = clr_busy_q ? '0 : s2_new;

  psum_bank_ram #(
    .DW(DATA_BITWIDTH),
    .AW(ADDR_BITWIDTH_GLB)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_ren),
    .rd_addr (ram_raddr),
    .rd_data (ram_q),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata)
  );

`ifdef PSUM_SAT_EN
  sat_res_t s2_res;
  logic     s2_clamp;
`endif

  // S2: pick the freshest old value (the previous cycle's write bypasses the RAM) and modify.
  always_comb begin
    s2_old = (wb_vld && (wb_addr == s2.addr)) ? wb_data : ram_q;
`ifdef PSUM_SAT_EN
    s2_res   = sat_add(s2_old, s2.data);
    s2_sum   = s2_res.sum;
    s2_clamp = s2.mode && s2_res.sat;
`else
    s2_sum   = s2_old + s2.data;
`endif
    s2_new = s2.mode ? s2_sum : s2.data;
  end

  // Write pipeline registers plus the last committed word kept for forwarding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld  <= 1'b0;
      s2      <= '0;
      wb_vld  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      s2_vld <= wr_acc;
      if (wr_acc) begin
        s2.addr <= w_addr_glb_psum;
        s2.data <= w_data_glb_psum;
        s2.mode <= accum_mode;
      end
      wb_vld <= s2_vld;
      if (s2_vld) begin
        wb_addr <= s2.addr;
        wb_data <= s2_new;
      end
    end
  end

  // Read response: forward the S2 result when the read hits the word being written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_of_rst   <= 1'b0;
      r_valid      <= 1'b0;
      rd_fwd_q     <= 1'b0;
      rd_fwd_dat_q <= '0;
    end else begin
      out_of_rst   <= 1'b1;
      r_valid      <= rd_acc;
      rd_fwd_q     <= rd_acc && s2_vld && (s2.addr == r_addr);
      rd_fwd_dat_q <= s2_new;
    end
  end

  assign r_data = r_valid ? (rd_fwd_q ? rd_fwd_dat_q : ram_q) : '0;

  // Clear sequencer: latch a start that arrives with writes in flight, then sweep every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_state  <= IDLE;
      clr_addr   <= '0;
      clr_pend   <= 1'b0;
      clr_busy_q <= 1'b0;
    end else begin
      case (clr_state)
        IDLE: begin
          if (clr_go) begin
            clr_state  <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_addr   <= '0;
            clr_pend   <= 1'b0;
          end else if (clear_start) begin
            clr_pend <= 1'b1;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            clr_state  <= IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: clr_state <= IDLE;
      endcase
    end
  end

`ifdef PSUM_SAT_EN
  logic sat_q;

  // Sticky clamp indicator, dropped when a sweep starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  sat_q <= 1'b0;
    else if (clr_go)             sat_q <= 1'b0;
    else if (s2_vld && s2_clamp) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_glb_psum_accum.sv
module tb_glb_psum_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en_glb_psum;
  logic [9:0]  w_addr_glb_psum;
  logic [15:0] w_data_glb_psum;
  logic        accum_mode;
  logic        write_ready;
  logic        read_en;
  logic [9:0]  r_addr;
  logic        read_ready;
  logic [15:0] r_data;
  logic        r_valid;
  logic        clear_start;
  logic        clear_busy;
  logic        sat_flag;

  int          n_checks = 0;
  int          n_fail   = 0;
  shortint     model_mem [1024];
  bit          model_sat;

  glb_psum_accum dut (
    .clk               (clk),
    .reset             (reset),
    .write_en_glb_psum (write_en_glb_psum),
    .w_addr_glb_psum   (w_addr_glb_psum),
    .w_data_glb_psum   (w_data_glb_psum),
    .accum_mode        (accum_mode),
    .write_ready       (write_ready),
    .read_en           (read_en),
    .r_addr            (r_addr),
    .read_ready        (read_ready),
    .r_data            (r_data),
    .r_valid           (r_valid),
    .clear_start       (clear_start),
    .clear_busy        (clear_busy),
    .sat_flag          (sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed 16-bit add, clamped or wrapped depending on the build.
  function automatic shortint model_acc(input shortint old, input shortint d);
    int s;
    s = int'(old) + int'(d);
`ifdef PSUM_SAT_EN
    if (s > 32767) begin
      s = 32767;
      model_sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      model_sat = 1'b1;
    end
`endif
    return shortint'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int d, input bit mode);
    write_en_glb_psum = 1'b1;
    w_addr_glb_psum   = a[9:0];
    w_data_glb_psum   = d[15:0];
    accum_mode        = mode;
    step();
    write_en_glb_psum = 1'b0;
    if (mode) model_mem[a] = model_acc(model_mem[a], shortint'(d));
    else      model_mem[a] = shortint'(d);
  endtask

  task automatic do_read(input int a, output logic [15:0] d, output logic v);
    read_en = 1'b1;
    r_addr  = a[9:0];
    step();
    d       = r_data;
    v       = r_valid;
    read_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write_en_glb_psum = 1'b0; w_addr_glb_psum = '0; w_data_glb_psum = '0; accum_mode = 1'b0;
    read_en = 1'b0; r_addr = '0; clear_start = 1'b0;
    model_sat = 1'b0;
    repeat (3) step();
    n_checks++; if (write_ready !== 1'b0) begin n_fail++; $display("FAIL reset_write_ready got %b want 0", write_ready); end
    n_checks++; if (read_ready !== 1'b0) begin n_fail++; $display("FAIL reset_read_ready got %b want 0", read_ready); end
    n_checks++; if (r_valid !== 1'b0 || r_data !== 16'h0) begin n_fail++; $display("FAIL reset_rport got v=%b d=%h want 0/0000", r_valid, r_data); end
    n_checks++; if (clear_busy !== 1'b0 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b sat=%b want 0/0", clear_busy, sat_flag); end
    reset = 1'b1;
    step();
    n_checks++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL release_write_ready got %b want 1", write_ready); end
    n_checks++; if (read_ready !== 1'b1) begin n_fail++; $display("FAIL release_read_ready got %b want 1", read_ready); end
  endtask

  task automatic test_overwrite_accum();
    logic [15:0] exp;
    do_write(5, 10, 1'b0);
    do_write(5, 7, 1'b1);
    exp = model_mem[5];
    read_en = 1'b1; r_addr = 10'd5;
    step();
    read_en = 1'b0;
    n_checks++; if (r_valid !== 1'b1) begin n_fail++; $display("FAIL ow_acc_valid got %b want 1", r_valid); end
    n_checks++; if (r_data !== exp) begin n_fail++; $display("FAIL ow_acc_data got %0d want %0d", r_data, exp); end
    step();
    n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL ow_acc_pulse got %b want 0", r_valid); end
  endtask

  task automatic test_saturation();
    logic [15:0] d, exp;
    logic        v;
    do_write(8, 32767, 1'b0);
    do_write(8, 5, 1'b1);
    exp = model_mem[8];
    do_read(8, d, v);
    n_checks++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL sat_pos got v=%b d=%h want 1/%h", v, d, exp); end
    n_checks++; if (sat_flag !== model_sat) begin n_fail++; $display("FAIL sat_flag_pos got %b want %b", sat_flag, model_sat); end
    do_write(9, 32'h8000, 1'b0);
    do_write(9, 32'hFFFF, 1'b1);
    exp = model_mem[9];
    do_read(9, d, v);
    n_checks++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL sat_neg got v=%b d=%h want 1/%h", v, d, exp); end
  endtask

  task automatic test_clear_full();
    int          cnt;
    int          bad_wr;
    logic [15:0] d;
    logic        v;
    for (int a = 0; a < 1024; a++) do_write(a, int'($urandom_range(1, 65535)), 1'b0);
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n_checks++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL clear_rise got %b want 1", clear_busy); end
    cnt = 0; bad_wr = 0;
    while (clear_busy === 1'b1 && cnt < 1100) begin
      if (write_ready !== 1'b0 || read_ready !== 1'b0) bad_wr++;
      cnt++;
      step();
    end
    n_checks++; if (cnt !== 1024) begin n_fail++; $display("FAIL clear_len got %0d want 1024", cnt); end
    n_checks++; if (bad_wr !== 0) begin n_fail++; $display("FAIL clear_ready_low got %0d ready cycles want 0", bad_wr); end
    n_checks++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL clear_end_ready got %b want 1", write_ready); end
    for (int a = 0; a < 1024; a++) model_mem[a] = 0;
    model_sat = 1'b0;
    n_checks++; if (sat_flag !== model_sat) begin n_fail++; $display("FAIL clear_sat got %b want %b", sat_flag, model_sat); end
    do_read(0, d, v);
    n_checks++; if (v !== 1'b1 || d !== 16'(model_mem[0])) begin n_fail++; $display("FAIL clear_rd0 got v=%b d=%h want 1/0000", v, d); end
    do_read(511, d, v);
    n_checks++; if (v !== 1'b1 || d !== 16'(model_mem[511])) begin n_fail++; $display("FAIL clear_rd511 got v=%b d=%h want 1/0000", v, d); end
    do_read(1023, d, v);
    n_checks++; if (v !== 1'b1 || d !== 16'(model_mem[1023])) begin n_fail++; $display("FAIL clear_rd1023 got v=%b d=%h want 1/0000", v, d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, exp;
    logic        v;
    do_write(3, 1, 1'b1);
    do_write(3, 2, 1'b1);
    do_write(3, 3, 1'b1);
    exp = model_mem[3];
    do_read(3, d, v);
    n_checks++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL b2b_accum got v=%b d=%0d want 1/%0d", v, d, exp); end
  endtask

  task automatic test_rw_conflict();
    logic [15:0] exp;
    write_en_glb_psum = 1'b1; w_addr_glb_psum = 10'd20; w_data_glb_psum = 16'h0055; accum_mode = 1'b0;
    read_en = 1'b1; r_addr = 10'd20;
    #1;
    n_checks++; if (read_ready !== 1'b0) begin n_fail++; $display("FAIL conflict_read_ready got %b want 0", read_ready); end
    @(posedge clk); #1;
    model_mem[20] = 16'sh0055;
    exp = model_mem[20];
    write_en_glb_psum = 1'b0;
    n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL conflict_no_valid got %b want 0", r_valid); end
    step();
    read_en = 1'b0;
    n_checks++; if (r_valid !== 1'b1 || r_data !== exp) begin n_fail++; $display("FAIL conflict_retry got v=%b d=%h want 1/%h", r_valid, r_data, exp); end
  endtask

  task automatic test_random();
    logic [15:0] d, exp;
    logic        v;
    int          a;
    int          errs;
    int          reads;
    errs = 0; reads = 0;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) begin
        do_write(a, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      end else begin
        exp = model_mem[a];
        do_read(a, d, v);
        reads++;
        if (v !== 1'b1 || d !== exp) begin
          errs++;
          $display("FAIL random_read addr=%0d got v=%b d=%h want 1/%h", a, v, d, exp);
        end
      end
    end
    n_checks += reads;
    n_fail   += errs;
    n_checks++; if (sat_flag !== model_sat) begin n_fail++; $display("FAIL random_sat got %b want %b", sat_flag, model_sat); end
  endtask

  task automatic test_reset_mid_clear();
    logic [15:0] d, exp;
    logic        v;
    do_write(50, 16'h1234, 1'b0);
    do_write(500, 16'h4321, 1'b0);
    write_en_glb_psum = 1'b1; w_addr_glb_psum = 10'd7; w_data_glb_psum = 16'h0009; accum_mode = 1'b0;
    clear_start = 1'b1;
    step();
    write_en_glb_psum = 1'b0; clear_start = 1'b0;
    n_checks++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL pend_wait1 got %b want 0", clear_busy); end
    step();
    n_checks++; if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL pend_wait2 got %b want 0", clear_busy); end
    step();
    n_checks++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL pend_start got %b want 1", clear_busy); end
    repeat (100) step();
    reset = 1'b0;
    for (int a = 0; a < 100; a++) model_mem[a] = 0;
    model_sat = 1'b0;
    step();
    reset = 1'b1;
    step();
    n_checks++; if (clear_busy !== 1'b0 || write_ready !== 1'b1 || sat_flag !== model_sat) begin
      n_fail++; $display("FAIL midclr_state got busy=%b wr=%b sat=%b want 0/1/0", clear_busy, write_ready, sat_flag);
    end
    exp = model_mem[50];
    do_read(50, d, v);
    n_checks++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL midclr_rd50 got v=%b d=%h want 1/%h", v, d, exp); end
    exp = model_mem[500];
    do_read(500, d, v);
    n_checks++; if (v !== 1'b1 || d !== exp) begin n_fail++; $display("FAIL midclr_rd500 got v=%b d=%h want 1/%h", v, d, exp); end
  endtask

  initial begin
    test_reset();
    test_overwrite_accum();
    test_saturation();
    test_clear_full();
    test_back_to_back();
    test_rw_conflict();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
